// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache feeding the fetch stage.
// Misses refill a whole line word by word from the memory controller.
module inst_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic [31:0] IF_PC_in,
  output logic        IF_flag_out,
  output logic [31:0] IF_inst_out,
  output logic        MC_req_out,
  output logic [31:0] MC_addr_out,
  input  logic        MC_done_in,
  input  logic [31:0] MC_data_in
);

  localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t                  r_state;
  logic [LINES-1:0]        r_valid;
  logic [TAG_BITS-1:0]     r_tag  [LINES];
  logic [31:0]             r_data [LINES*WORDS];
  logic [TAG_BITS-1:0]     r_miss_tag;
  logic [INDEX_BITS-1:0]   r_miss_index;
  logic [OFFSET_BITS-1:0]  r_cnt;

  logic [TAG_BITS-1:0]     w_tag;
  logic [INDEX_BITS-1:0]   w_index;
  logic [OFFSET_BITS-1:0]  w_word;
  logic                    w_hit;
  logic                    w_last;
  logic                    w_fill;
  logic                    w_unused;

  assign w_tag    = IF_PC_in[31 -: TAG_BITS];
  assign w_index  = IF_PC_in[2+OFFSET_BITS +: INDEX_BITS];
  assign w_word   = IF_PC_in[2 +: OFFSET_BITS];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last   = &r_cnt;
  assign w_fill   = rst && rdy && (r_state == REFILL) && MC_done_in;
  assign w_unused = &{1'b0, IF_PC_in[1:0]};

  // Arrays carry no reset; validity alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[{r_miss_index, r_cnt}] <= MC_data_in;
      if (w_last)
        r_tag[r_miss_index] <= r_miss_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_cnt        <= '0;
      IF_flag_out  <= 1'b0;
      IF_inst_out  <= '0;
      MC_req_out   <= 1'b0;
      MC_addr_out  <= '0;
    end else if (rdy) begin
      unique case (r_state)
        IDLE: begin
          if (jump_wrong) begin
            IF_flag_out <= 1'b0;
          end else if (w_hit) begin
            IF_flag_out <= 1'b1;
            IF_inst_out <= r_data[{w_index, w_word}];
          end else begin
            IF_flag_out      <= 1'b0;
            r_miss_tag       <= w_tag;
            r_miss_index     <= w_index;
            r_cnt            <= '0;
            r_valid[w_index] <= 1'b0;
            r_state          <= REFILL;
            MC_req_out       <= 1'b1;
            MC_addr_out      <= {w_tag, w_index,
                                 {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          IF_flag_out <= 1'b0;
          if (MC_done_in) begin
            if (w_last) begin
              r_valid[r_miss_index] <= 1'b1;
              MC_req_out            <= 1'b0;
              r_state               <= IDLE;
            end else begin
              r_cnt       <= r_cnt + OFFSET_BITS'(1);
              MC_addr_out <= MC_addr_out + 32'd4;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed table, corner sequences
// and randomized traffic against a line-level cache model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, MC_done_in;
  logic [31:0] IF_PC_in, MC_data_in;
  logic        IF_flag_out, MC_req_out;
  logic [31:0] IF_inst_out, MC_addr_out;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .jump_wrong  (jump_wrong),
    .IF_PC_in    (IF_PC_in),
    .IF_flag_out (IF_flag_out),
    .IF_inst_out (IF_inst_out),
    .MC_req_out  (MC_req_out),
    .MC_addr_out (MC_addr_out),
    .MC_done_in  (MC_done_in),
    .MC_data_in  (MC_data_in)
  );

  int checks = 0;
  int errors = 0;

  // Model: which tag each line holds, plus one outstanding refill.
  bit          m_val [64];
  int unsigned m_tag [64];
  bit          m_act;
  int unsigned m_idx, m_tagr, m_words;
  logic        m_flag;
  logic [31:0] m_inst, m_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic y, input logic j,
                            input logic d, input logic [31:0] pc);
    int unsigned i, t;
    i = (pc >> 4) & 63;
    t = pc >> 10;
    if (!r) begin
      for (int k = 0; k < 64; k++) m_val[k] = 1'b0;
      m_act  = 1'b0;
      m_flag = 1'b0;
      m_inst = '0;
      m_addr = '0;
    end else if (y) begin
      if (m_act) begin
        m_flag = 1'b0;
        if (d) begin
          m_words++;
          if (m_words == 4) begin
            m_val[m_idx] = 1'b1;
            m_tag[m_idx] = m_tagr;
            m_act        = 1'b0;
          end else begin
            m_addr = m_addr + 4;
          end
        end
      end else if (j) begin
        m_flag = 1'b0;
      end else if (m_val[i] && m_tag[i] == t) begin
        m_flag = 1'b1;
        m_inst = mem({pc[31:2], 2'b00});
      end else begin
        m_flag  = 1'b0;
        m_val[i] = 1'b0;
        m_act   = 1'b1;
        m_idx   = i;
        m_tagr  = t;
        m_words = 0;
        m_addr  = (t << 10) | (i << 4);
      end
    end
  endtask

  task automatic step(input logic r, input logic y, input logic j,
                      input logic d, input logic [31:0] pc);
    logic dd;
    dd         = d & y;
    rst        = r;
    rdy        = y;
    jump_wrong = j;
    IF_PC_in   = pc;
    MC_done_in = dd;
    MC_data_in = mem(MC_addr_out);
    model_edge(r, y, j, dd, pc);
    @(posedge clk);
    #1;
    chk("flag", {31'b0, IF_flag_out}, {31'b0, m_flag});
    chk("inst", IF_inst_out, m_inst);
    chk("req", {31'b0, MC_req_out}, {31'b0, m_act});
    chk("addr", MC_addr_out, m_addr);
  endtask

  task automatic fill4(input logic [31:0] pc, input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      chk("refill_addr", MC_addr_out, base + 32'(4 * k));
      step(1, 1, 0, 1, pc);
    end
    chk("refill_done_req", {31'b0, MC_req_out}, 32'd0);
  endtask

  typedef struct {
    logic        r, y, j, d;
    logic [31:0] pc;
    logic        ef, er;
    logic [31:0] ea, ei;
  } vec_t;

  vec_t tv [11];

  initial begin
    logic [31:0] pc;
    logic        r, y, j, d;

    rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0;
    IF_PC_in = '0; MC_done_in = 1'b0; MC_data_in = '0;
    for (int k = 0; k < 64; k++) begin
      m_val[k] = 1'b0;
      m_tag[k] = 0;
    end
    m_act = 0; m_flag = 0; m_inst = '0; m_addr = '0;
    m_idx = 0; m_tagr = 0; m_words = 0;

    // reset, refill of line 0 with a wait cycle, then sequential hits
    tv[0]  = '{0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0};
    tv[1]  = '{1, 1, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0};
    tv[2]  = '{1, 1, 0, 1, 32'h0, 0, 1, 32'h4, 32'h0};
    tv[3]  = '{1, 1, 0, 1, 32'h0, 0, 1, 32'h8, 32'h0};
    tv[4]  = '{1, 1, 0, 0, 32'h0, 0, 1, 32'h8, 32'h0};
    tv[5]  = '{1, 1, 0, 1, 32'h0, 0, 1, 32'hC, 32'h0};
    tv[6]  = '{1, 1, 0, 1, 32'h0, 0, 0, 32'hC, 32'h0};
    tv[7]  = '{1, 1, 0, 0, 32'h0, 1, 0, 32'hC, mem(32'h0)};
    tv[8]  = '{1, 1, 0, 0, 32'h4, 1, 0, 32'hC, mem(32'h4)};
    tv[9]  = '{1, 1, 0, 0, 32'h8, 1, 0, 32'hC, mem(32'h8)};
    tv[10] = '{1, 1, 0, 0, 32'hC, 1, 0, 32'hC, mem(32'hC)};

    for (int k = 0; k < 11; k++) begin
      step(tv[k].r, tv[k].y, tv[k].j, tv[k].d, tv[k].pc);
      chk("tv_flag", {31'b0, IF_flag_out}, {31'b0, tv[k].ef});
      chk("tv_req", {31'b0, MC_req_out}, {31'b0, tv[k].er});
      chk("tv_addr", MC_addr_out, tv[k].ea);
      chk("tv_inst", IF_inst_out, tv[k].ei);
    end

    // conflicting tag evicts line 0, then 0x0 misses again
    step(1, 1, 0, 0, 32'h400);
    chk("t3_req", {31'b0, MC_req_out}, 32'd1);
    fill4(32'h400, 32'h400);
    step(1, 1, 0, 0, 32'h400);
    chk("t3_hit", {31'b0, IF_flag_out}, 32'd1);
    step(1, 1, 0, 0, 32'h0);
    chk("t3_remiss", {31'b0, MC_req_out}, 32'd1);
    fill4(32'h0, 32'h0);

    // flush on a hit cycle, then flush during a refill
    step(1, 1, 0, 0, 32'h0);
    chk("t4_hit", {31'b0, IF_flag_out}, 32'd1);
    step(1, 1, 1, 0, 32'h0);
    chk("t4_flush", {31'b0, IF_flag_out}, 32'd0);
    step(1, 1, 0, 0, 32'h400);
    step(1, 1, 0, 1, 32'h400);
    step(1, 1, 0, 1, 32'h400);
    chk("t4_w2_addr", MC_addr_out, 32'h408);
    step(1, 1, 1, 1, 32'h400);
    step(1, 1, 0, 1, 32'h400);
    chk("t4_done", {31'b0, MC_req_out}, 32'd0);
    step(1, 1, 0, 0, 32'h400);
    chk("t4_hit2", {31'b0, IF_flag_out}, 32'd1);

    // stall mid-refill
    step(1, 1, 0, 0, 32'h10);
    step(1, 1, 0, 1, 32'h10);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 32'h10);
      chk("t5_hold_addr", MC_addr_out, 32'h14);
      chk("t5_hold_req", {31'b0, MC_req_out}, 32'd1);
    end
    for (int k = 1; k < 4; k++) begin
      chk("t5_addr", MC_addr_out, 32'h10 + 32'(4 * k));
      step(1, 1, 0, 1, 32'h10);
    end
    step(1, 1, 0, 0, 32'h1C);
    chk("t5_hit", IF_inst_out, mem(32'h1C));

    // reset mid-refill, restart, late done while idle
    step(1, 1, 0, 0, 32'h20);
    step(1, 1, 0, 1, 32'h20);
    step(0, 1, 0, 0, 32'h20);
    chk("t6_req_drop", {31'b0, MC_req_out}, 32'd0);
    step(1, 1, 0, 0, 32'h0);
    fill4(32'h0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    chk("t6_hit", {31'b0, IF_flag_out}, 32'd1);
    step(1, 1, 0, 1, 32'h4);
    chk("t6_late_done", {31'b0, MC_req_out}, 32'd0);
    step(1, 1, 0, 0, 32'h20);
    chk("t6_invalid", {31'b0, MC_req_out}, 32'd1);
    fill4(32'h20, 32'h20);

    // randomized traffic over two tags and four lines
    pc = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) != 0);
      y = ($urandom_range(0, 9) != 0);
      j = ($urandom_range(0, 9) == 0);
      d = MC_req_out ? ($urandom_range(0, 1) == 1)
                     : ($urandom_range(0, 49) == 0);
      if (IF_flag_out || $urandom_range(0, 3) == 0)
        pc = (32'($urandom_range(0, 1)) << 10) |
             (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) |
             32'($urandom_range(0, 3));
      step(r, y, j, d, pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
